// File: rtl/pe_traffic_gen.sv
// Single-flit packet injector for one PE port: emits NUM_PKTS flits with
// LFSR-driven destinations/payloads over a valid/ready handshake.
module pe_traffic_gen #(
  parameter int unsigned ADDRESS  = 0,
  parameter int unsigned NUM_PE   = 8,
  parameter int unsigned NUM_PKTS = 100,
  parameter int unsigned GAP      = 0,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic        o_done,
  output logic [15:0] o_sent_count,
  output logic [31:0] o_stall_cycles
);

  localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [2:0]  SRC       = 3'(ADDRESS);
  localparam logic [2:0]  DEST_MASK = 3'(NUM_PE - 1);
  localparam logic [2:0]  DEST_ALT  = 3'((ADDRESS + 1) % NUM_PE);
  localparam logic [15:0] PKTS      = 16'(NUM_PKTS);
  localparam logic [7:0]  GAP_LOAD  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [7:0]  gap_cnt;
  logic [15:0] lfsr_adv;
  logic [15:0] count_inc;

  always_comb begin
    lfsr_adv  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    count_inc = o_sent_count + 16'd1;
  end

  // NUM_PE is a power of two, so masking the low LFSR bits picks a PE.
  function automatic logic [31:0] make_flit(input logic [15:0] l, input logic [9:0] seq);
    logic [2:0] d;
    d = l[2:0] & DEST_MASK;
    if (d == SRC) d = DEST_ALT;
    return {d, SRC, seq, l};
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      lfsr           <= SEED_INIT;
      gap_cnt        <= '0;
      o_data         <= '0;
      o_data_valid   <= 1'b0;
      o_done         <= 1'b0;
      o_sent_count   <= '0;
      o_stall_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (PKTS == 16'd0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state        <= SEND;
              o_data_valid <= 1'b1;
              o_data       <= make_flit(lfsr, o_sent_count[9:0]);
            end
          end
        end
        SEND: begin
          if (!i_data_ready) begin
            if (o_stall_cycles != '1) o_stall_cycles <= o_stall_cycles + 32'd1;
          end else begin
            o_sent_count <= count_inc;
            lfsr         <= lfsr_adv;
            if (count_inc == PKTS) begin
              state        <= DONE;
              o_data_valid <= 1'b0;
              o_data       <= '0;
              o_done       <= 1'b1;
            end else if (GAP == 0) begin
              // Next flit is built from the post-transfer LFSR and count.
              o_data <= make_flit(lfsr_adv, count_inc[9:0]);
            end else begin
              state        <= WAIT;
              o_data_valid <= 1'b0;
              gap_cnt      <= GAP_LOAD;
            end
          end
        end
        WAIT: begin
          if (gap_cnt == 8'd0) begin
            state        <= SEND;
            o_data_valid <= 1'b1;
            o_data       <= make_flit(lfsr, o_sent_count[9:0]);
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Bench for pe_traffic_gen: four differently-parameterised instances checked by
// a per-instance expected-flit queue plus directed timing checks.
module tb_pe_traffic_gen;

  localparam int unsigned NI = 4;
  localparam int unsigned P_ADDR  [NI] = '{0, 2, 3, 1};
  localparam int unsigned P_NPE   [NI] = '{8, 4, 8, 2};
  localparam int unsigned P_NPKTS [NI] = '{4, 3, 1000, 0};
  localparam int unsigned P_GAP   [NI] = '{0, 3, 0, 0};
  localparam int unsigned P_SEED  [NI] = '{32'hACE1, 0, 32'h1234, 32'hACE1};

  logic        clk;
  logic        rst_n [NI];
  logic        start [NI];
  logic        ready [NI];
  logic        valid [NI];
  logic        done  [NI];
  logic [31:0] data  [NI];
  logic [31:0] stall [NI];
  logic [15:0] cnt   [NI];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mem [NI][1024];
  int          head [NI];
  int          tail [NI];
  logic        held [NI];
  logic [31:0] hold_data [NI];
  logic [7:0]  dest_seen;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pe_traffic_gen #(
      .ADDRESS (P_ADDR[g]),
      .NUM_PE  (P_NPE[g]),
      .NUM_PKTS(P_NPKTS[g]),
      .GAP     (P_GAP[g]),
      .SEED    (16'(P_SEED[g]))
    ) u_dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n[g]),
      .i_start       (start[g]),
      .o_data        (data[g]),
      .o_data_valid  (valid[g]),
      .i_data_ready  (ready[g]),
      .o_done        (done[g]),
      .o_sent_count  (cnt[g]),
      .o_stall_cycles(stall[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [31:0] model_flit(input int unsigned addr, input int unsigned npe,
                                             input logic [15:0] l, input int unsigned seq);
    int unsigned d;
    int unsigned s;
    logic [2:0]  d3;
    logic [2:0]  s3;
    logic [9:0]  q;
    d = 32'(l) % npe;
    if (d == addr) d = (addr + 1) % npe;
    s  = seq % 1024;
    d3 = d[2:0];
    s3 = addr[2:0];
    q  = s[9:0];
    return {d3, s3, q, l};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input int g);
    logic [15:0] l;
    l = (P_SEED[g] == 0) ? 16'hACE1 : 16'(P_SEED[g]);
    for (int unsigned k = 0; k < P_NPKTS[g]; k++) begin
      exp_mem[g][tail[g] % 1024] = model_flit(P_ADDR[g], P_NPE[g], l, k);
      tail[g]++;
      l = lfsr_next(l);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int g, input int budget);
    for (int i = 0; i < budget && !done[g]; i++) tick(1);
    chk("done_reached", 32'(done[g]), 32'd1);
  endtask

  // Monitor: pops one expected flit per handshake, checks hold stability.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst_n[g]) begin
        head[g] = tail[g];
        held[g] = 1'b0;
      end else begin
        if (held[g]) chk($sformatf("hold%0d", g), {valid[g] ? 1'b1 : 1'b0, data[g][30:0]},
                         {1'b1, hold_data[g][30:0]});
        if (held[g] && data[g][31] !== hold_data[g][31]) begin
          checks++;
          errors++;
          $display("FAIL hold_msb%0d: got %h expected %h", g, data[g], hold_data[g]);
        end
        if (valid[g] && ready[g]) begin
          if (head[g] == tail[g]) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flit%0d: got %h expected none", g, data[g]);
          end else begin
            chk($sformatf("flit%0d_%0d", g, head[g]), data[g], exp_mem[g][head[g] % 1024]);
            head[g]++;
          end
          if (g == 2) dest_seen[data[g][31:29]] = 1'b1;
        end
        held[g]      = valid[g] && !ready[g];
        hold_data[g] = data[g];
      end
    end
  end

  initial begin
    logic [8:0] pat;
    int         sent_m;
    int         stall_m;
    dest_seen = '0;
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0; start[g] = 1'b0; ready[g] = 1'b0;
      head[g] = 0; tail[g] = 0; held[g] = 1'b0; hold_data[g] = '0;
    end
    tick(2);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_data%0d", g), data[g], 32'd0);
      chk($sformatf("rst_ctl%0d", g), {13'd0, valid[g], done[g], cnt[g]}, 32'd0);
      chk($sformatf("rst_stall%0d", g), stall[g], 32'd0);
      rst_n[g] = 1'b1;
    end

    // Back-to-back, GAP=0
    ready[0] = 1'b1;
    issue(0);
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    chk("b2b_first_payload", {16'd0, data[0][15:0]}, 32'h0000ACE1);
    chk("b2b_first_dest", {29'd0, data[0][31:29]}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_valid%0d", i), 32'(valid[0]), 32'd1);
      tick(1);
    end
    chk("b2b_done", {valid[0], done[0]}, 32'b01);
    chk("b2b_count", 32'(cnt[0]), 32'd4);
    start[0] = 1'b1;
    tick(2);
    start[0] = 1'b0;
    chk("done_ignores_start", {valid[0], done[0], cnt[0]}, {1'b0, 1'b1, 16'd4});

    // Backpressure on the first flit
    rst_n[0] = 1'b0; ready[0] = 1'b0;
    tick(1);
    rst_n[0] = 1'b1;
    issue(0);
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(5);
    chk("bp_stall", stall[0], 32'd5);
    chk("bp_count_held", 32'(cnt[0]), 32'd0);
    ready[0] = 1'b1;
    tick(1);
    chk("bp_count_after", 32'(cnt[0]), 32'd1);
    chk("bp_lfsr_once", {16'd0, data[0][15:0]}, {16'd0, lfsr_next(16'hACE1)});
    wait_done(0, 20);
    chk("bp_stall_final", stall[0], 32'd5);
    chk("bp_count_final", 32'(cnt[0]), 32'd4);

    // Reset while a flit is being offered against backpressure
    rst_n[0] = 1'b0;
    tick(1);
    rst_n[0] = 1'b1; ready[0] = 1'b0;
    issue(0);
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(2);
    chk("mid_valid_before", 32'(valid[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    chk("mid_rst_data", data[0], 32'd0);
    chk("mid_rst_ctl", {13'd0, valid[0], done[0], cnt[0]}, 32'd0);
    chk("mid_rst_stall", stall[0], 32'd0);
    tick(1);
    rst_n[0] = 1'b1; ready[0] = 1'b1;
    issue(0);
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    chk("mid_restart_payload", {16'd0, data[0][15:0]}, 32'h0000ACE1);
    chk("mid_restart_seq", {22'd0, data[0][25:16]}, 32'd0);
    wait_done(0, 20);
    chk("mid_queue_drained", head[0], tail[0]);

    // GAP=3: valid 1,0,0,0,1,0,0,0,1 then done
    ready[1] = 1'b1;
    issue(1);
    start[1] = 1'b1;
    tick(1);
    start[1] = 1'b0;
    pat = 9'b100010001;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("gap_valid%0d", i), 32'(valid[1]), 32'(pat[8 - i]));
      tick(1);
    end
    chk("gap_done", {valid[1], done[1], cnt[1]}, {1'b0, 1'b1, 16'd3});

    // 1000 packets from ADDRESS=3 with random ready
    issue(2);
    start[2] = 1'b1;
    tick(1);
    start[2] = 1'b0;
    sent_m = 0; stall_m = 0;
    for (int c = 0; c < 20000 && sent_m < 1000; c++) begin
      ready[2] = 1'($urandom_range(0, 1));
      if (ready[2]) sent_m++;
      else stall_m++;
      tick(1);
    end
    ready[2] = 1'b0;
    chk("rnd_done", 32'(done[2]), 32'd1);
    chk("rnd_count", 32'(cnt[2]), 32'd1000);
    chk("rnd_stall", stall[2], 32'(stall_m));
    chk("rnd_dest_cover", 32'(dest_seen), 32'h000000F7);
    chk("rnd_queue_drained", head[2], tail[2]);

    // NUM_PKTS=0
    ready[3] = 1'b1;
    start[3] = 1'b1;
    tick(1);
    start[3] = 1'b0;
    chk("zero_done", {valid[3], done[3], cnt[3]}, {1'b0, 1'b1, 16'd0});
    start[3] = 1'b1;
    tick(3);
    start[3] = 1'b0;
    chk("zero_done_hold", {valid[3], done[3], cnt[3]}, {1'b0, 1'b1, 16'd0});

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
